// File: rtl/countdown_timer_pkg.sv
// Shared types for the countdown timer: FSM state encoding.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/countdown_timer_tick_divider.sv
// Prescaler: counts enabled cycles and emits a tick when the count matches prescale.
import countdown_timer_pkg::*;

module tick_divider #(
    parameter int PrescaleSize = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    enable,
    input  logic [PrescaleSize-1:0] prescale,
    output logic                    tick
);

    logic [PrescaleSize-1:0] phase;

    // Compared against the live prescale, so a mid-run change applies at the next compare.
    assign tick = enable && !clear && (phase == prescale);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            phase <= '0;
        end else if (enable) begin
            phase <= tick ? '0 : phase + PrescaleSize'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Prescaled countdown timer with IDLE/RUN/DONE FSM.
// Define COUNTDOWN_TIMER_AUTORELOAD_EN to reload from the last loaded value on expiry.
import countdown_timer_pkg::*;

module countdown_timer #(
    parameter int Size         = 8,
    parameter int PrescaleSize = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    count,
    input  logic [PrescaleSize-1:0] prescale,
    input  logic                    load,
    input  logic [Size-1:0]         load_data,
    input  logic                    start,
    input  logic                    abort,
    output logic [Size-1:0]         data_o,
    output logic                    busy,
    output logic                    done,
    output logic                    expired
);

    state_t          state;
    logic            tick;
    logic            div_clear;
    logic            div_enable;
    logic [Size-1:0] effective;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    logic [Size-1:0] reload;
`endif

    // Holding the divider clear outside RUN guarantees a fresh phase on every entry to RUN.
    assign div_clear  = (state != RUN) || abort;
    assign div_enable = (state == RUN) && count;
    assign effective  = load ? load_data : data_o;
    assign busy       = (state == RUN);
    assign expired    = (state == DONE);

    tick_divider #(
        .PrescaleSize(PrescaleSize)
    ) u_tick_divider (
        .clock   (clock),
        .reset   (reset),
        .clear   (div_clear),
        .enable  (div_enable),
        .prescale(prescale),
        .tick    (tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            data_o <= '0;
            done   <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            reload <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (load) begin
                        data_o <= load_data;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                        reload <= load_data;
`endif
                        state  <= IDLE;
                    end
                    // Start overrides both the load-driven IDLE move and a same-cycle abort.
                    if (start) begin
                        if (effective != '0) begin
                            state <= RUN;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (data_o == Size'(1)) begin
                            done <= 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                            if (reload != '0) begin
                                data_o <= reload;
                            end else begin
                                data_o <= '0;
                                state  <= DONE;
                            end
`else
                            data_o <= '0;
                            state  <= DONE;
`endif
                        end else if (data_o != '0) begin
                            data_o <= data_o - Size'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random traffic against a behavioural model.
module tb_countdown_timer;

    localparam int Size         = 8;
    localparam int PrescaleSize = 4;
    localparam int W            = Size + 3;
    localparam int MIdle        = 0;
    localparam int MRun         = 1;
    localparam int MDone        = 2;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    count;
    logic [PrescaleSize-1:0] prescale;
    logic                    load;
    logic [Size-1:0]         load_data;
    logic                    start;
    logic                    abort;
    logic [Size-1:0]         data_o;
    logic                    busy;
    logic                    done;
    logic                    expired;

    countdown_timer #(
        .Size        (Size),
        .PrescaleSize(PrescaleSize)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .count    (count),
        .prescale (prescale),
        .load     (load),
        .load_data(load_data),
        .start    (start),
        .abort    (abort),
        .data_o   (data_o),
        .busy     (busy),
        .done     (done),
        .expired  (expired)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    // Behavioural model: mode, remaining value, last loaded value, count cycles since last tick.
    int   m_mode;
    int   m_val;
    int   m_reload;
    int   m_phase;
    logic m_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_step(input logic rst, input logic ld, input int ldv, input logic st,
                              input logic ab, input logic cn, input int ps);
        m_done = 1'b0;
        if (rst) begin
            m_mode = MIdle; m_val = 0; m_reload = 0; m_phase = 0;
        end else if (m_mode != MRun) begin
            if (ld) begin
                m_val = ldv;
                m_reload = ldv;
                m_mode = MIdle;
            end
            if (st) begin
                if (m_val != 0) begin
                    m_mode = MRun;
                    m_phase = 0;
                end else begin
                    m_mode = MDone;
                    m_done = 1'b1;
                end
            end
        end else if (ab) begin
            m_mode = MIdle;
        end else if (cn) begin
            if (m_phase == ps) begin
                m_phase = 0;
                m_val = m_val - 1;
                if (m_val == 0) begin
                    m_done = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                    if (m_reload != 0) m_val = m_reload;
                    else m_mode = MDone;
`else
                    m_mode = MDone;
`endif
                end
            end else begin
                m_phase = (m_phase + 1) % (1 << PrescaleSize);
            end
        end
    endtask

    // Drive one cycle, predict, then compare all outputs just after the edge.
    task automatic step(input logic rst, input logic ld, input int ldv, input logic st,
                        input logic ab, input logic cn, input int ps, input string tag);
        logic [W-1:0] expv;
        reset = rst; load = ld; load_data = Size'(ldv); start = st;
        abort = ab; count = cn; prescale = PrescaleSize'(ps);
        model_step(rst, ld, ldv, st, ab, cn, ps);
        exp_q.push_back({Size'(m_val), m_mode == MRun, m_done, m_mode == MDone});
        @(posedge clock);
        #1;
        expv = exp_q.pop_front();
        check(tag, 32'({data_o, busy, done, expired}), 32'(expv));
    endtask

    task automatic run(input int ps, input string tag);
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, ps, tag);
    endtask

    initial begin
        int done_at;
        reset = 1'b1; load = 1'b0; load_data = '0; start = 1'b0;
        abort = 1'b0; count = 1'b0; prescale = '0;
        m_mode = MIdle; m_val = 0; m_reload = 0; m_phase = 0; m_done = 1'b0;

        step(1'b1, 1'b1, 9, 1'b1, 1'b0, 1'b1, 0, "reset");
        check("reset_outputs", 32'({data_o, busy, done, expired}), 32'(0));

        // Load 5, prescale 0, count always high.
        step(1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b1, 0, "l5_start");
        check("l5_busy", 32'(busy), 32'(1));
        for (int i = 1; i <= 5; i++) begin
            run(0, "l5_run");
`ifndef COUNTDOWN_TIMER_AUTORELOAD_EN
            check("l5_value", 32'(data_o), 32'(5 - i));
`endif
            check("l5_done", 32'(done), 32'(i == 5));
        end
`ifndef COUNTDOWN_TIMER_AUTORELOAD_EN
        run(0, "l5_after");
        check("l5_expired", 32'(expired), 32'(1));
        check("l5_done_once", 32'(done), 32'(0));
`endif

        // Load 3, prescale 2: done nine cycles after start.
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, "rst2");
        step(1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b1, 2, "l3_start");
        done_at = -1;
        for (int i = 1; i <= 20; i++) begin
            run(2, "l3_run");
            if (done && done_at < 0) done_at = i;
        end
        check("l3_done_cycle", 32'(done_at), 32'(9));

        // Abort at 6, then resume.
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, "rst3");
        step(1'b0, 1'b1, 10, 1'b1, 1'b0, 1'b1, 0, "l10_start");
        for (int i = 0; i < 4; i++) run(0, "l10_run");
        step(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 0, "abort");
        check("abort_hold", 32'(data_o), 32'(6));
        check("abort_idle", 32'({busy, done, expired}), 32'(0));
        step(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1, 0, "restart");
        check("restart_busy", 32'({data_o, busy}), 32'({8'd6, 1'b1}));
        run(0, "resume");
        check("resume_value", 32'(data_o), 32'(5));

        // Reset mid-run at 4.
        for (int i = 0; i < 1; i++) run(0, "to4");
        check("at4", 32'(data_o), 32'(4));
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 0, "reset_run");
        check("reset_run_zero", 32'({data_o, busy, done, expired}), 32'(0));

        // Load 0 with start.
        step(1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1, 0, "l0_start");
        check("l0_done", 32'({busy, done, expired}), 32'({1'b0, 1'b1, 1'b1}));
        run(0, "l0_after");
        check("l0_after", 32'({busy, done, expired}), 32'({1'b0, 1'b0, 1'b1}));

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
        step(1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b1, 0, "ar_start");
        for (int i = 0; i < 4; i++) begin
            run(0, "ar_run");
            check("ar_value", 32'({data_o, busy, done}),
                  32'({Size'(i % 2 == 0 ? 1 : 2), 1'b1, 1'(i % 2)}));
        end
`endif

        // Random traffic with occasional prescale changes and rare resets.
        begin
            int ps = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 15) == 0) ps = $urandom_range(0, 3);
                step($urandom_range(0, 199) == 0,
                     $urandom_range(0, 7) == 0,
                     $urandom_range(0, 6),
                     $urandom_range(0, 7) == 0,
                     $urandom_range(0, 15) == 0,
                     $urandom_range(0, 3) != 0,
                     ps, "random");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter Size, default 8: width of the count value.
REQ-002 Parameter PrescaleSize, default 4: width of the prescale divider.
REQ-003 The ports SHALL be as follows, clock and reset first:
- clock  input  1: clock; all logic on the rising edge.
- reset  input  1: reset, synchronous, active-high.
- count  input  1: external tick enable; advances the prescaler when high.
- prescale  input  PrescaleSize: divide ratio minus one.
- load  input  1: load request.
- load_data  input  Size: value to load.
- start  input  1: start request.
- abort  input  1: stop request.
- data_o  output  Size: current remaining count (registered).
- busy  output  1: high in RUN.
- done  output  1: one-cycle pulse on expiry.
- expired  output  1: level, high in DONE.

Function
REQ-004 The FSM SHALL have exactly three states, IDLE, RUN and DONE, with busy = (state==RUN) and expired = (state==DONE).
REQ-005 Load behaviour:
- load in IDLE or DONE SHALL set data_o <= load_data and the reload register <= load_data.
- A load in DONE SHALL move to IDLE.
- load in RUN SHALL be ignored.
REQ-006 Start behaviour:
- start in IDLE or DONE SHALL enter RUN if the effective value is nonzero.
- The effective value is load_data if load is high in the same cycle, else data_o.
- If the effective value is 0, the block SHALL enter DONE and pulse done on the next cycle.
REQ-007 Prescaler:
- In RUN, each cycle with count=1 SHALL advance the prescaler.
- A qualified tick occurs when the prescaler equals prescale; the prescaler then wraps to 0.
- prescale=0 SHALL give one tick per count cycle.
REQ-008 Each qualified tick in RUN SHALL decrement data_o by 1 (modulo 2^Size is never reached; 0 is never decremented).
REQ-009 Expiry: a tick with data_o==1 SHALL set data_o to 0, pulse done for exactly one cycle on the following cycle edge, and move to DONE (base build).
REQ-010 abort in RUN SHALL move to IDLE, keep data_o unchanged and produce no done; abort takes priority over a same-cycle tick.
REQ-011 The prescaler SHALL clear on entry to RUN and on abort.
REQ-012 start and abort asserted together in IDLE or DONE: start wins. In RUN: abort wins and start is ignored.
REQ-013 Changing prescale mid-RUN SHALL take effect at the next comparison, with no reset of the prescaler.

Reset
REQ-014 While reset is high, on the clock edge:
- state <= IDLE and data_o <= 0;
- reload register <= 0 and prescaler <= 0;
- done = 0, busy = 0 and expired = 0.
REQ-015 reset mid-RUN SHALL abort without a done pulse; reset has priority over all inputs.

Configuration
REQ-016 With macro COUNTDOWN_TIMER_AUTORELOAD_EN defined, expiry behaviour SHALL change as follows:
- data_o SHALL reload from the reload register instead of reaching DONE.
- The block SHALL stay in RUN and pulse done on every expiry.
- A reload value of 0 SHALL enter DONE instead.
REQ-017 Without COUNTDOWN_TIMER_AUTORELOAD_EN, REQ-009 SHALL hold and the reload register SHALL be omitted from the build.

Structure
REQ-018 A shared package countdown_timer_pkg SHALL hold the state encoding typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
REQ-019 The prescaler SHALL be a sub-module named tick_divider with these ports:
- inputs: clock, reset, clear, enable, prescale;
- output: tick.

Verification
REQ-020 Load 5, prescale 0, start, count=1 constant -> data_o 4,3,2,1,0 on consecutive cycles; done pulses once; expired=1 thereafter.
REQ-021 Load 3, prescale 2, count=1 -> one decrement every 3 cycles; done 9 cycles after start.
REQ-022 Load 10, start, abort at data_o=6 -> IDLE, data_o holds 6, no done; a restart resumes from 6.
REQ-023 Load 0 with start in the same cycle -> DONE plus a done pulse on the next cycle; busy never high.
REQ-024 Reset asserted at data_o=4 in RUN -> all outputs 0 and state IDLE on the next edge; no done.
REQ-025 Autoreload build: load 2, start, count=1 -> done every 2 ticks, busy stays 1, and data_o cycles 1,2,1,2.
